// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand -- AES-128 key schedule with an internal round-key file.
//
// Accepts one 128-bit cipher key on start and writes round keys 0..NR into
// an 11 x 128 register file, one key per clock. The encryption datapath
// reads keys combinationally by index.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request expansion of key_in (sampled only in IDLE)
//   key_in       cipher key, [127:96] = w0
//   busy         expansion in progress
//   done         one-cycle pulse after the last round key is written
//   keys_valid   stored keys are complete and match the last accepted key
//   rk_wr        one-cycle strobe per round key written
//   rk_wr_idx    index of the key just written
//   rk_wr_data   value of the key just written
//   rk_rd_idx    read index; indices above NR read as zero
//   rk_rd_data   combinational read of key[rk_rd_idx]
// ---------------------------------------------------------------------------

// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inverse = a^254 = product of a^(2^k) for k = 1..7; 0 maps to 0
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_expand #(
  parameter int unsigned NR    = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [127:0]       key_in,
  output logic               busy,
  output logic               done,
  output logic               keys_valid,
  output logic               rk_wr,
  output logic [IDX_W-1:0]   rk_wr_idx,
  output logic [127:0]       rk_wr_data,
  input  logic [IDX_W-1:0]   rk_rd_idx,
  output logic [127:0]       rk_rd_data
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   round_q, round_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               keys_valid_q, keys_valid_d;
  logic               rk_wr_q, rk_wr_d;
  logic [IDX_W-1:0]   rk_wr_idx_q, rk_wr_idx_d;
  logic [127:0]       rk_wr_data_q, rk_wr_data_d;
  logic [127:0]       key_q [NR+1];
  logic [127:0]       key_d [NR+1];

  logic [IDX_W-1:0]   prev_idx;
  logic [127:0]       prev_key;
  logic [31:0]        rot_w3;
  logic [31:0]        sub_w3;
  logic [7:0]         rcon;
  logic [31:0]        t, n0, n1, n2, n3;
  logic [127:0]       next_key;

  function automatic logic [7:0] rcon_of(input logic [IDX_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Round function operates on the previously written key; round 0 never
  // reaches here, the guard only keeps the index in range.
  always_comb begin
    prev_idx = (round_q == '0) ? '0 : round_q - 1'b1;
    prev_key = key_q[prev_idx];
    rot_w3   = {prev_key[23:0], prev_key[31:24]};
    rcon     = rcon_of(round_q);
    t        = sub_w3 ^ {rcon, 24'h0};
    n0       = prev_key[127:96] ^ t;
    n1       = prev_key[95:64]  ^ n0;
    n2       = prev_key[63:32]  ^ n1;
    n3       = prev_key[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (
      .in_byte  (rot_w3[8*g +: 8]),
      .out_byte (sub_w3[8*g +: 8])
    );
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    rk_wr_d      = 1'b0;
    rk_wr_idx_d  = rk_wr_idx_q;
    rk_wr_data_d = rk_wr_data_q;
    key_d        = key_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d[0]     = key_in;
          rk_wr_d      = 1'b1;
          rk_wr_idx_d  = '0;
          rk_wr_data_d = key_in;
          round_d      = {{(IDX_W-1){1'b0}}, 1'b1};
          busy_d       = 1'b1;
          keys_valid_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        key_d[round_q] = next_key;
        rk_wr_d        = 1'b1;
        rk_wr_idx_d    = round_q;
        rk_wr_data_d   = next_key;
        if (round_q == LAST) begin
          busy_d       = 1'b0;
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
          round_d      = '0;
          state_d      = ST_IDLE;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_wr_q      <= 1'b0;
      rk_wr_idx_q  <= '0;
      rk_wr_data_q <= '0;
      for (int unsigned i = 0; i <= NR; i++) key_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rk_wr_q      <= rk_wr_d;
      rk_wr_idx_q  <= rk_wr_idx_d;
      rk_wr_data_q <= rk_wr_data_d;
      for (int unsigned i = 0; i <= NR; i++) key_q[i] <= key_d[i];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_wr      = rk_wr_q;
  assign rk_wr_idx  = rk_wr_idx_q;
  assign rk_wr_data = rk_wr_data_q;
  assign rk_rd_data = (rk_rd_idx <= LAST) ? key_q[rk_rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand -- self-checking bench for aes_key_expand.
// Reference model: S-box built by the multiplicative-generator walk and the
// FIPS-197 word-wise key expansion over a 44-word array.
// ---------------------------------------------------------------------------
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, keys_valid, rk_wr;
  logic [3:0]   rk_wr_idx;
  logic [127:0] rk_wr_data;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] model_rk [11];

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expand #(.NR(10), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_wr      (rk_wr),
    .rk_wr_idx  (rk_wr_idx),
    .rk_wr_data (rk_wr_data),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++)
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic read_check(input string tag, input int idx, input logic [127:0] exp);
    rk_rd_idx = 4'(idx);
    #1;
    check(tag, rk_rd_data, exp);
  endtask

  task automatic launch(input logic [127:0] key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
  endtask

  // Follows one expansion edge by edge; start already driven for the
  // accepting edge. glitch>0 re-pulses start with a junk key after edge T+glitch.
  task automatic expand_check(input logic [127:0] key, input int glitch,
                              input bit chain, input logic [127:0] next_key);
    compute_model(key);
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rk_wr[%0d]", k), {127'b0, rk_wr}, 128'd1);
      check($sformatf("rk_wr_idx[%0d]", k), {124'b0, rk_wr_idx}, 128'(k));
      check($sformatf("rk_wr_data[%0d]", k), rk_wr_data, model_rk[k]);
      check($sformatf("busy[%0d]", k), {127'b0, busy}, 128'(k < 10));
      check($sformatf("done[%0d]", k), {127'b0, done}, 128'(k == 10));
      check($sformatf("keys_valid[%0d]", k), {127'b0, keys_valid}, 128'(k == 10));
      read_check("rd_idx11", 11, '0);
      read_check("rd_idx15", 15, '0);
      if (k == 10)
        for (int r = 0; r <= 10; r++) read_check($sformatf("rd_key%0d", r), r, model_rk[r]);
      if (k == 0) start = 1'b0;
      if (glitch > 0 && k == glitch) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (glitch > 0 && k == glitch + 1) start = 1'b0;
      if (k == 10 && chain) begin
        start  = 1'b1;
        key_in = next_key;
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("idle_done", {127'b0, done}, '0);
      check("idle_rk_wr", {127'b0, rk_wr}, '0);
      check("idle_busy", {127'b0, busy}, '0);
      check("idle_keys_valid", {127'b0, keys_valid}, 128'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    key_in    = '0;
    rk_rd_idx = '0;
    build_sbox();
    #12;
    check("rst_busy", {127'b0, busy}, '0);
    check("rst_done", {127'b0, done}, '0);
    check("rst_keys_valid", {127'b0, keys_valid}, '0);
    check("rst_rk_wr", {127'b0, rk_wr}, '0);
    check("rst_rk_wr_idx", {124'b0, rk_wr_idx}, '0);
    check("rst_rk_wr_data", rk_wr_data, '0);
    for (int i = 0; i < 16; i++) read_check($sformatf("rst_rd%0d", i), i, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // known-answer key 1
    launch(KEY1);
    expand_check(KEY1, 0, 1'b0, '0);
    read_check("kat1_key1", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_check("kat1_key10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // known-answer key 2
    launch(KEY2);
    expand_check(KEY2, 0, 1'b0, '0);
    read_check("kat2_key1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_check("kat2_key10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start re-pulsed mid-expansion is ignored
    launch(KEY1);
    expand_check(KEY1, 3, 1'b0, '0);
    read_check("ign_key10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // reset mid-expansion
    launch(KEY1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {127'b0, busy}, '0);
    check("midrst_done", {127'b0, done}, '0);
    check("midrst_keys_valid", {127'b0, keys_valid}, '0);
    check("midrst_rk_wr", {127'b0, rk_wr}, '0);
    for (int i = 0; i < 16; i++) read_check($sformatf("midrst_rd%0d", i), i, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("postrst_done", {127'b0, done}, '0);
      check("postrst_busy", {127'b0, busy}, '0);
      check("postrst_rk_wr", {127'b0, rk_wr}, '0);
    end

    // back-to-back: restart in the done cycle
    launch(KEY1);
    expand_check(KEY1, 0, 1'b1, KEY2);
    expand_check(KEY2, 0, 1'b0, '0);
    read_check("b2b_key1", 1, 128'ha0fafe1788542cb123a339392a6c7605);

    // random keys, some with ignored start pulses
    for (int n = 0; n < 6; n++) begin
      logic [127:0] rkey;
      rkey = {$urandom, $urandom, $urandom, $urandom};
      launch(rkey);
      expand_check(rkey, int'($urandom_range(0, 8)), 1'b0, '0);
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        read_check($sformatf("rand_rd%0d", idx), idx, (idx <= 10) ? model_rk[idx] : '0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
